// File: rtl/i2c_target_mem.sv
// rtl/i2c_target_mem.sv - I2C target with a 128x8 register memory
// Oversamples SCL/SDA, matches a 7-bit address, services pointer/data writes and sequential reads.
module i2c_target_mem #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  state_t     state_q, state_d;
  logic       scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_h_q, scl_h_d;
  logic       sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_h_q, sda_h_d;
  logic       scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
  logic       start_q, start_d, stop_q, stop_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic [6:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_valid_q, wr_valid_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] mem_q [128];

  always_comb begin
    scl_s1_d   = scl_i;
    scl_s2_d   = scl_s1_q;
    scl_h_d    = scl_s2_q;
    sda_s1_d   = sda_i;
    sda_s2_d   = sda_s1_q;
    sda_h_d    = sda_s2_q;
    // Edge flags are registered so every reaction lands one clock after detection.
    scl_rise_d = scl_s2_q & ~scl_h_q;
    scl_fall_d = ~scl_s2_q & scl_h_q;
    start_d    = ~sda_s2_q & sda_h_q & scl_s2_q & scl_h_q;
    stop_d     = sda_s2_q & ~sda_h_q & scl_s2_q & scl_h_q;

    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (start_q) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else if (stop_q) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else if (scl_rise_q) begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (cnt_q != 4'd8) begin
            shift_d = {shift_q[6:0], sda_s2_q};
            cnt_d   = cnt_q + 4'd1;
          end
        end
        RDATA: cnt_d = cnt_q + 4'd1;
        RACK: begin
          if (sda_s2_q) state_d = IDLE;
          else          cnt_d   = 4'd1;
        end
        default: ;
      endcase
    end else if (scl_fall_q) begin
      case (state_q)
        ADDR: begin
          if (cnt_q == 4'd8) begin
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d  = ADDR_ACK;
              sda_oe_d = 1'b1;
            end else begin
              state_d  = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          cnt_d = 4'd0;
          if (shift_q[0]) begin
            state_d  = RDATA;
            tx_d     = mem_q[ptr_q];
            sda_oe_d = ~mem_q[ptr_q][7];
          end else begin
            state_d  = PTR;
            sda_oe_d = 1'b0;
          end
        end
        PTR: begin
          if (cnt_q == 4'd8) begin
            ptr_d    = shift_q[6:0];
            state_d  = PTR_ACK;
            sda_oe_d = 1'b1;
          end
        end
        PTR_ACK, WDATA_ACK: begin
          state_d  = WDATA;
          cnt_d    = 4'd0;
          sda_oe_d = 1'b0;
        end
        WDATA: begin
          if (cnt_q == 4'd8) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = shift_q;
            ptr_d      = ptr_q + 7'd1;
            state_d    = WDATA_ACK;
            sda_oe_d   = 1'b1;
          end
        end
        RDATA: begin
          if (cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            ptr_d    = ptr_q + 7'd1;
            state_d  = RACK;
            cnt_d    = 4'd0;
          end else begin
            sda_oe_d = ~tx_q[3'd7 - cnt_q[2:0]];
          end
        end
        RACK: begin
          // Only a fall that follows the sampled ACK rise moves on to the next byte.
          if (cnt_q == 4'd1) begin
            state_d  = RDATA;
            cnt_d    = 4'd0;
            tx_d     = mem_q[ptr_q];
            sda_oe_d = ~mem_q[ptr_q][7];
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != IDLE) && (state_d != ADDR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_h_q    <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_h_q    <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'd0;
      tx_q       <= 8'd0;
      ptr_q      <= 7'd0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 7'd0;
      wr_data_q  <= 8'd0;
      for (int i = 0; i < 128; i++) mem_q[i] <= 8'd0;
    end else begin
      scl_s1_q   <= scl_s1_d;
      scl_s2_q   <= scl_s2_d;
      scl_h_q    <= scl_h_d;
      sda_s1_q   <= sda_s1_d;
      sda_s2_q   <= sda_s2_d;
      sda_h_q    <= sda_h_d;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      if (wr_valid_d) mem_q[ptr_q] <= shift_q;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_target_mem.sv
// tb/tb_i2c_target_mem.sv - bench for i2c_target_mem
// Bit-level I2C initiator plus a byte-level target model; outputs compared every clock.
module tb_i2c_target_mem;

  localparam int P_IDLE  = 0;
  localparam int P_ADDR  = 1;
  localparam int P_PTR   = 2;
  localparam int P_WDATA = 3;
  localparam int P_RDATA = 4;
  localparam int P_IGN   = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, busy, wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  logic [7:0]  mem_m [128];
  logic [6:0]  ptr_m;
  int          phase_m;
  logic        exp_oe, exp_busy, exp_wv, chk_en;
  logic [6:0]  exp_wa;
  logic [7:0]  exp_wd;
  logic [14:0] wlog [$];
  int          checks = 0;
  int          errors = 0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_mem #(.DEV_ADDR(7'h50)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("sda_oe", sda_oe, exp_oe);
      check("busy", busy, exp_busy);
      check("wr_valid", wr_valid, exp_wv);
      if (exp_wv) begin
        check("wr_addr", wr_addr, exp_wa);
        check("wr_data", wr_data, exp_wd);
      end
    end
    if (!rst && wr_valid) wlog.push_back({wr_addr, wr_data});
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One SCL period; the target reacts to each pin event four clocks later.
  task automatic slot(input logic mbit, input logic oe_f, input logic busy_f, input logic wv_f,
                      input logic [6:0] wa, input logic [7:0] wd, input logic busy_r,
                      output logic line_r);
    scl_m = 1'b0;
    ticks(4);
    exp_oe   = oe_f;
    exp_busy = busy_f;
    if (wv_f) begin
      exp_wv = 1'b1;
      exp_wa = wa;
      exp_wd = wd;
    end
    tick();
    exp_wv = 1'b0;
    sda_m  = mbit;
    ticks(3);
    scl_m  = 1'b1;
    line_r = sda_line;
    ticks(4);
    exp_busy = busy_r;
    ticks(4);
  endtask

  task automatic start_cond;
    sda_m = 1'b0;
    ticks(4);
    exp_oe   = 1'b0;
    exp_busy = 1'b0;
    phase_m  = P_ADDR;
    ticks(4);
  endtask

  task automatic stop_cond;
    logic ln;
    slot(1'b0, 1'b0, exp_busy, 1'b0, 7'd0, 8'd0, exp_busy, ln);
    sda_m = 1'b1;
    ticks(4);
    exp_oe   = 1'b0;
    exp_busy = 1'b0;
    phase_m  = P_IDLE;
    ticks(4);
  endtask

  task automatic repstart;
    logic ln;
    slot(1'b1, 1'b0, exp_busy, 1'b0, 7'd0, 8'd0, exp_busy, ln);
    start_cond();
  endtask

  task automatic write_byte(input logic [7:0] b);
    logic ln, oe, bz, wv, want;
    logic [6:0] wa;
    for (int i = 0; i < 8; i++) slot(b[7-i], 1'b0, exp_busy, 1'b0, 7'd0, 8'd0, exp_busy, ln);
    oe = 1'b0;
    bz = exp_busy;
    wv = 1'b0;
    wa = ptr_m;
    case (phase_m)
      P_ADDR: begin
        if (b[7:1] == 7'h50) begin
          oe = 1'b1;
          bz = 1'b1;
          phase_m = b[0] ? P_RDATA : P_PTR;
        end else begin
          bz = 1'b0;
          phase_m = P_IGN;
        end
      end
      P_PTR: begin
        oe = 1'b1;
        ptr_m = b[6:0];
        phase_m = P_WDATA;
      end
      P_WDATA: begin
        oe = 1'b1;
        wv = 1'b1;
        mem_m[ptr_m] = b;
        ptr_m = ptr_m + 7'd1;
      end
      default: ;
    endcase
    slot(1'b1, oe, bz, wv, wa, b, bz, ln);
    want = !oe;
    check("ack_line", ln, want);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] got);
    logic [7:0] tx;
    logic ln, bz;
    tx = mem_m[ptr_m];
    for (int i = 0; i < 8; i++) begin
      slot(1'b1, !tx[7-i], exp_busy, 1'b0, 7'd0, 8'd0, exp_busy, ln);
      got[7-i] = ln;
    end
    ptr_m = ptr_m + 7'd1;
    bz = nack ? 1'b0 : exp_busy;
    slot(nack, 1'b0, exp_busy, 1'b0, 7'd0, 8'd0, bz, ln);
    if (nack) phase_m = P_IDLE;
    check("read_byte", got, tx);
  endtask

  initial begin
    logic [7:0] got;
    logic ln;
    chk_en   = 1'b0;
    exp_oe   = 1'b0;
    exp_busy = 1'b0;
    exp_wv   = 1'b0;
    exp_wa   = 7'd0;
    exp_wd   = 8'd0;
    ptr_m    = 7'd0;
    phase_m  = P_IDLE;
    for (int i = 0; i < 128; i++) mem_m[i] = 8'd0;

    ticks(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    rst = 1'b0;
    tick();
    chk_en = 1'b1;

    // Write pointer 5 then two data bytes.
    start_cond();
    write_byte(8'hA0);
    write_byte(8'h05);
    write_byte(8'h3C);
    write_byte(8'h7E);
    stop_cond();
    check("busy_after_stop", busy, 0);
    check("wlog_count_write", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("wlog_write0", wlog[0], {7'd5, 8'h3C});
      check("wlog_write1", wlog[1], {7'd6, 8'h7E});
    end
    check("model_ptr_after_write", ptr_m, 7'd7);
    wlog.delete();

    // Read back through a repeated START.
    start_cond();
    write_byte(8'hA0);
    write_byte(8'h05);
    repstart();
    write_byte(8'hA1);
    read_byte(1'b0, got);
    check("read_first_lit", got, 8'h3C);
    read_byte(1'b1, got);
    check("read_second_lit", got, 8'h7E);
    check("busy_after_nack", busy, 0);
    stop_cond();

    // Pointer wrap from 127 to 0.
    start_cond();
    write_byte(8'hA0);
    write_byte(8'h7F);
    write_byte(8'h11);
    write_byte(8'h22);
    stop_cond();
    check("wlog_count_wrap", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("wlog_wrap0", wlog[0], {7'd127, 8'h11});
      check("wlog_wrap1", wlog[1], {7'd0, 8'h22});
    end
    wlog.delete();
    start_cond();
    write_byte(8'hA0);
    write_byte(8'h7F);
    repstart();
    write_byte(8'hA1);
    read_byte(1'b0, got);
    check("wrap_read0_lit", got, 8'h11);
    read_byte(1'b1, got);
    check("wrap_read1_lit", got, 8'h22);
    stop_cond();

    // Address mismatch: the target must stay silent.
    start_cond();
    write_byte(8'hA2);
    write_byte(8'hFF);
    stop_cond();
    check("wlog_count_mismatch", wlog.size(), 0);
    check("busy_mismatch", busy, 0);

    // Abort a data byte half way through.
    start_cond();
    write_byte(8'hA0);
    write_byte(8'h10);
    write_byte(8'h5A);
    stop_cond();
    wlog.delete();
    start_cond();
    write_byte(8'hA0);
    write_byte(8'h10);
    slot(1'b1, 1'b0, exp_busy, 1'b0, 7'd0, 8'd0, exp_busy, ln);
    slot(1'b0, 1'b0, exp_busy, 1'b0, 7'd0, 8'd0, exp_busy, ln);
    slot(1'b1, 1'b0, exp_busy, 1'b0, 7'd0, 8'd0, exp_busy, ln);
    slot(1'b1, 1'b0, exp_busy, 1'b0, 7'd0, 8'd0, exp_busy, ln);
    stop_cond();
    check("wlog_count_abort", wlog.size(), 0);
    start_cond();
    write_byte(8'hA1);
    read_byte(1'b1, got);
    check("abort_read_lit", got, 8'h5A);
    stop_cond();

    // Reset while the target is pulling SDA low for a read bit.
    start_cond();
    write_byte(8'hA0);
    write_byte(8'h05);
    repstart();
    write_byte(8'hA1);
    slot(1'b1, !mem_m[ptr_m][7], exp_busy, 1'b0, 7'd0, 8'd0, exp_busy, ln);
    check("pre_rst_sda_oe", sda_oe, 1);
    chk_en = 1'b0;
    rst = 1'b1;
    tick();
    check("mid_rst_sda_oe", sda_oe, 0);
    check("mid_rst_busy", busy, 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    ticks(2);
    rst = 1'b0;
    for (int i = 0; i < 128; i++) mem_m[i] = 8'd0;
    ptr_m    = 7'd0;
    phase_m  = P_IDLE;
    exp_oe   = 1'b0;
    exp_busy = 1'b0;
    exp_wv   = 1'b0;
    tick();
    chk_en = 1'b1;
    start_cond();
    write_byte(8'hA1);
    read_byte(1'b1, got);
    check("post_rst_read_lit", got, 8'h00);
    stop_cond();

    ticks(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
